arashi_wr_arbiter: RTL and testbench

Round-robin write arbiter that shares one cache write port between THREAD_NUM requesting threads. It sits between the per-thread write requests (decoded from `ctrl`) and `arashi_cache`. It picks one requester per cycle, captures its data into a single-entry output register, and presents that entry downstream with a valid/ready handshake. Ownership rotates fairly, so no thread can be starved while the others keep requesting.

---
 rtl/arashi_wr_arbiter.sv | 81 ++++++++
 tb/tb_arashi_wr_arbiter.sv | 121 ++++++++++++
 2 files changed

// File: rtl/arashi_wr_arbiter.sv
// Round-robin write arbiter: picks one of THREAD_NUM requesters per cycle,
// captures its data into a single-entry output register and hands that
// entry downstream through a valid/ready handshake.
module arashi_wr_arbiter #(
    parameter int DATA_WIDTH       = 32,
    parameter int THREAD_NUM_WIDTH = 2,
    localparam int THREAD_NUM      = 1 << THREAD_NUM_WIDTH
) (
    input  logic                             clk,
    input  logic                             rst,
    input  logic [THREAD_NUM-1:0]            req,
    input  logic [DATA_WIDTH*THREAD_NUM-1:0] data_in,
    output logic [THREAD_NUM-1:0]            grant,
    output logic                             out_valid,
    output logic [THREAD_NUM_WIDTH-1:0]      out_tid,
    output logic [DATA_WIDTH-1:0]            out_data,
    input  logic                             out_ready
);

    generate
        if (THREAD_NUM_WIDTH < 2 || THREAD_NUM_WIDTH > 4) begin : g_bad_width
            $error("arashi_wr_arbiter: THREAD_NUM_WIDTH must be in 2..4");
        end
    endgenerate

    logic                        out_valid_q;
    logic [THREAD_NUM_WIDTH-1:0] out_tid_q;
    logic [DATA_WIDTH-1:0]       out_data_q;
    logic [THREAD_NUM_WIDTH-1:0] ptr_q;

    logic                        load;
    logic                        found;
    logic [THREAD_NUM_WIDTH-1:0] win;
    logic [THREAD_NUM_WIDTH-1:0] idx;

    // The register is free when empty or being drained this cycle.
    assign load = (!out_valid_q || out_ready) && (|req);

    // Scan from ptr upward (wrapping by truncation) for the first requester.
    always_comb begin
        found = 1'b0;
        win   = '0;
        idx   = '0;
        for (int k = 0; k < THREAD_NUM; k++) begin
            idx = ptr_q + k[THREAD_NUM_WIDTH-1:0];
            if (!found && req[idx]) begin
                found = 1'b1;
                win   = idx;
            end
        end
    end

    // One-hot accept pulse, suppressed while reset is held.
    always_comb begin
        grant = '0;
        if (load && !rst) grant[win] = 1'b1;
    end

    // Output entry and priority pointer; load takes precedence over drain
    // so a consume and a new capture in one cycle leave no bubble.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            out_valid_q <= 1'b0;
            out_tid_q   <= '0;
            out_data_q  <= '0;
            ptr_q       <= '0;
        end else if (load) begin
            out_valid_q <= 1'b1;
            out_tid_q   <= win;
            out_data_q  <= data_in[DATA_WIDTH*win +: DATA_WIDTH];
            ptr_q       <= win + 1'b1;
        end else if (out_ready) begin
            out_valid_q <= 1'b0;
        end
    end

    assign out_valid = out_valid_q;
    assign out_tid   = out_tid_q;
    assign out_data  = out_data_q;

endmodule

// File: tb/tb_arashi_wr_arbiter.sv
// Directed bench for arashi_wr_arbiter with hand-computed expectations.
module tb_arashi_wr_arbiter;

    localparam int DW = 32;
    localparam int TW = 2;
    localparam int TN = 4;

    logic              clk = 1'b0;
    logic              rst;
    logic [TN-1:0]     req;
    logic [DW*TN-1:0]  data_in;
    logic [TN-1:0]     grant;
    logic              out_valid;
    logic [TW-1:0]     out_tid;
    logic [DW-1:0]     out_data;
    logic              out_ready;

    int total = 0;
    int bad   = 0;

    arashi_wr_arbiter #(.DATA_WIDTH(DW), .THREAD_NUM_WIDTH(TW)) dut (
        .clk(clk), .rst(rst), .req(req), .data_in(data_in), .grant(grant),
        .out_valid(out_valid), .out_tid(out_tid), .out_data(out_data),
        .out_ready(out_ready)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // Apply inputs now (just after a rising edge), check grant mid-cycle,
    // then check the registered entry just after the next rising edge.
    task automatic cyc(input string tag, input logic [3:0] r, input logic rdy,
                       input logic [3:0] gexp, input logic vexp,
                       input logic [1:0] texp, input logic [31:0] dexp);
        req       = r;
        out_ready = rdy;
        @(negedge clk);
        chk({tag, ".grant"}, {28'd0, grant}, {28'd0, gexp});
        @(posedge clk); #1;
        chk({tag, ".valid"}, {31'd0, out_valid}, {31'd0, vexp});
        chk({tag, ".tid"}, {30'd0, out_tid}, {30'd0, texp});
        chk({tag, ".data"}, out_data, dexp);
    endtask

    task automatic pulse_rst();
        req = '0;
        out_ready = 1'b0;
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
    endtask

    initial begin
        // Reset with arbitrary inputs.
        rst       = 1'b1;
        req       = 4'($urandom);
        out_ready = 1'($urandom);
        data_in   = {$urandom, $urandom, $urandom, $urandom};
        @(posedge clk); #1;
        @(negedge clk);
        chk("rst.valid", {31'd0, out_valid}, 32'd0);
        chk("rst.tid", {30'd0, out_tid}, 32'd0);
        chk("rst.data", out_data, 32'd0);
        chk("rst.grant", {28'd0, grant}, 32'd0);
        @(posedge clk); #1;
        rst = 1'b0;
        cyc("idle", 4'b0000, 1'b1, 4'b0000, 1'b0, 2'd0, 32'd0);

        // Single requester; leaves ptr at 3.
        for (int i = 0; i < TN; i++) data_in[DW*i +: DW] = 32'h1000 + i;
        data_in[DW*2 +: DW] = 32'hA5A5_0002;
        cyc("single", 4'b0100, 1'b1, 4'b0100, 1'b1, 2'd2, 32'hA5A5_0002);

        // Full contention from ptr=0.
        pulse_rst();
        for (int i = 0; i < TN; i++) data_in[DW*i +: DW] = 32'h1000 + i;
        for (int c = 0; c < 6; c++)
            cyc($sformatf("full%0d", c), 4'b1111, 1'b1, 4'(1 << (c % 4)), 1'b1,
                2'(c % 4), 32'h1000 + (c % 4));

        // Bring ptr to 3, then wrap/skip with two requesters.
        cyc("tothr2", 4'b0100, 1'b1, 4'b0100, 1'b1, 2'd2, 32'h1002);
        cyc("wrap0", 4'b0011, 1'b1, 4'b0001, 1'b1, 2'd0, 32'h1000);
        cyc("wrap1", 4'b0011, 1'b1, 4'b0010, 1'b1, 2'd1, 32'h1001);
        cyc("wrap2", 4'b0011, 1'b1, 4'b0001, 1'b1, 2'd0, 32'h1000);

        // Backpressure: hold thread 1's entry, then release.
        cyc("bp.ld", 4'b0010, 1'b1, 4'b0010, 1'b1, 2'd1, 32'h1001);
        for (int c = 0; c < 3; c++)
            cyc($sformatf("bp.stall%0d", c), 4'b1111, 1'b0, 4'b0000, 1'b1, 2'd1, 32'h1001);
        cyc("bp.go", 4'b1111, 1'b1, 4'b0100, 1'b1, 2'd2, 32'h1002);

        // Drain with no requests: valid drops, entry fields hold.
        cyc("drain", 4'b0000, 1'b1, 4'b0000, 1'b0, 2'd2, 32'h1002);
        cyc("rdy_idle", 4'b0000, 1'b1, 4'b0000, 1'b0, 2'd2, 32'h1002);

        // Reach valid=1, ptr=2, then reset mid-operation.
        cyc("pre_rst", 4'b0010, 1'b1, 4'b0010, 1'b1, 2'd1, 32'h1001);
        req       = 4'b1111;
        out_ready = 1'b1;
        rst       = 1'b1;
        #1;
        chk("midrst.valid", {31'd0, out_valid}, 32'd0);
        chk("midrst.grant", {28'd0, grant}, 32'd0);
        @(posedge clk); #1;
        rst = 1'b0;
        cyc("post_rst", 4'b1111, 1'b1, 4'b0001, 1'b1, 2'd0, 32'h1000);
        cyc("post_rst2", 4'b1111, 1'b1, 4'b0010, 1'b1, 2'd1, 32'h1001);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
